// File: rtl/pattern_pkg.sv
// Shared types for the pattern stream source: FSM state encoding and the default byte width.
package pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    ACK_LOW,
    ACK_RECOVER,
    DONE
  } state_t;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/pattern_byte_ram.sv
// Byte buffer for the stream source: synchronous write, asynchronous (combinational) read.
module pattern_byte_ram #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; contents survive rst and are only defined once written.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pattern_stream_source.sv
// Streams a loaded byte buffer to a pattern detector, pausing for an ack-low handshake
// on every found_pattern and counting the matches of the current run.
module pattern_stream_source
  import pattern_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ACK_LOW_CYCLES = 1,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     reset_sync,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH):0]   stream_len,
  input  logic                     start,
  input  logic                     found_pattern,
  output logic [DATA_W-1:0]        data,
  output logic                     ack,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         match_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            TW       = (ACK_LOW_CYCLES > 1) ? $clog2(ACK_LOW_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_LOW_CYCLES - 1);
  localparam logic [AW:0]   IDX_ONE  = (AW+1)'(1);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [AW:0]       r_idx, w_idx_nxt;
  logic [AW:0]       r_len, w_len_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TW-1:0]     r_tmr, w_tmr_nxt;

  logic              w_wr_ok;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_ram_rd;
  logic [DATA_W-1:0] w_byte;

  assign w_wr_ok   = wr_en & ~r_busy;
  assign w_rd_addr = (r_state == STREAM || r_state == ACK_RECOVER) ? r_idx[AW-1:0] : '0;

  pattern_byte_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rd)
  );

  // Forward a same-cycle write so a write+start pair presents the new byte 0.
  assign w_byte = (w_wr_ok && wr_addr == w_rd_addr) ? wr_data : w_ram_rd;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_ack_nxt   = r_ack;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_cnt_nxt = '0;
          if (stream_len != '0) begin
            w_len_nxt   = stream_len;
            w_data_nxt  = w_byte;
            w_idx_nxt   = IDX_ONE;
            w_ack_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_state_nxt = STREAM;
          end else begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      STREAM: begin
        if (found_pattern) begin
          w_ack_nxt   = 1'b0;
          w_tmr_nxt   = TMR_LOAD;
          w_state_nxt = ACK_LOW;
          if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
        end else if (r_idx == r_len) begin
          w_ack_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_data_nxt = w_byte;
          w_idx_nxt  = r_idx + IDX_ONE;
        end
      end
      ACK_LOW: begin
        if (r_tmr == '0) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK_RECOVER;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      ACK_RECOVER: begin
        // The byte after the matched one is shown on the first STREAM clock.
        w_state_nxt = STREAM;
        if (r_idx != r_len) begin
          w_data_nxt = w_byte;
          w_idx_nxt  = r_idx + IDX_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  assign data        = r_data;
  assign ack         = r_ack;
  assign busy        = r_busy;
  assign done        = r_done;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_pattern_stream_source.sv
// Directed bench for pattern_stream_source: streaming, match handshakes, boundaries and reset.
module tb_pattern_stream_source;

  logic       clk = 1'b0;
  logic       reset_sync;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] stream_len;
  logic       start;
  logic       found_pattern;
  logic [7:0] data;
  logic       ack;
  logic       busy;
  logic       done;
  logic [7:0] match_count;

  int checks = 0;
  int errors = 0;

  pattern_stream_source dut (
    .clk           (clk),
    .reset_sync    (reset_sync),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .stream_len    (stream_len),
    .start         (start),
    .found_pattern (found_pattern),
    .data          (data),
    .ack           (ack),
    .busy          (busy),
    .done          (done),
    .match_count   (match_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] e_data, input logic e_ack,
                            input logic e_busy, input logic e_done, input logic [7:0] e_cnt);
    checks++;
    if (data !== e_data || ack !== e_ack || busy !== e_busy || done !== e_done ||
        match_count !== e_cnt) begin
      errors++;
      $display("FAIL %s: got data=%h ack=%b busy=%b done=%b cnt=%0d, want data=%h ack=%b busy=%b done=%b cnt=%0d",
               name, data, ack, busy, done, match_count, e_data, e_ack, e_busy, e_done, e_cnt);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [5:0] len);
    stream_len = len;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: done=%b after %0d cycles, want 1", name, done, n);
    end
  endtask

  task automatic test_reset();
    reset_sync = 1'b0;
    #2;
    expect_out("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset_sync = 1'b1;
  endtask

  task automatic test_stream();
    load_ramp();
    start_run(6'd32);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (data !== 8'(i) || ack !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_byte%0d: got data=%h ack=%b busy=%b, want data=%h ack=1 busy=1",
                 i, data, ack, busy, 8'(i));
      end
      tick();
    end
    expect_out("stream_done", 8'h1F, 1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic test_match();
    start_run(6'd32);
    tick(5);
    expect_out("match_at5", 8'h05, 1'b1, 1'b1, 1'b0, 8'd0);
    found_pattern = 1'b1;
    tick();
    found_pattern = 1'b0;
    expect_out("match_ack_low", 8'h05, 1'b0, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("match_recover", 8'h05, 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("match_resume", 8'h06, 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("match_next", 8'h07, 1'b1, 1'b1, 1'b0, 8'd1);
    wait_done("match_drain");
    expect_out("match_end", 8'h1F, 1'b0, 1'b0, 1'b1, 8'd1);
  endtask

  task automatic test_held_flag();
    start_run(6'd32);
    tick(10);
    expect_out("held_at0A", 8'h0A, 1'b1, 1'b1, 1'b0, 8'd0);
    found_pattern = 1'b1;
    tick();
    expect_out("held_ack_low", 8'h0A, 1'b0, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("held_recover", 8'h0A, 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    found_pattern = 1'b0;
    expect_out("held_single_count", 8'h0B, 1'b1, 1'b1, 1'b0, 8'd1);
    found_pattern = 1'b1;
    tick();
    found_pattern = 1'b0;
    expect_out("held_second_count", 8'h0B, 1'b0, 1'b1, 1'b0, 8'd2);
    tick(2);
    expect_out("held_resume", 8'h0C, 1'b1, 1'b1, 1'b0, 8'd2);
    wait_done("held_drain");
  endtask

  task automatic test_last_byte();
    start_run(6'd32);
    tick(31);
    expect_out("last_at1F", 8'h1F, 1'b1, 1'b1, 1'b0, 8'd0);
    found_pattern = 1'b1;
    tick();
    found_pattern = 1'b0;
    expect_out("last_ack_low", 8'h1F, 1'b0, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("last_recover", 8'h1F, 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("last_stream", 8'h1F, 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("last_done", 8'h1F, 1'b0, 1'b0, 1'b1, 8'd1);
    tick();
    expect_out("last_hold", 8'h1F, 1'b0, 1'b0, 1'b1, 8'd1);
  endtask

  task automatic test_reset_mid();
    start_run(6'd32);
    tick(11);
    expect_out("mid_before", 8'h0B, 1'b1, 1'b1, 1'b0, 8'd0);
    reset_sync = 1'b0;
    #1;
    expect_out("mid_async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    #1;
    reset_sync = 1'b1;
    start_run(6'd4);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("restart_byte%0d", i), 8'(i), 1'b1, 1'b1, 1'b0, 8'd0);
      tick();
    end
    expect_out("restart_done", 8'h03, 1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic test_len0_and_busy();
    start_run(6'd0);
    expect_out("len0", 8'h03, 1'b0, 1'b0, 1'b1, 8'd0);
    start_run(6'd8);
    expect_out("busy_start", 8'h00, 1'b1, 1'b1, 1'b0, 8'd0);
    wr_en      = 1'b1;
    wr_addr    = 5'd2;
    wr_data    = 8'hAA;
    stream_len = 6'd2;
    start      = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    expect_out("busy_start_ignored", 8'h01, 1'b1, 1'b1, 1'b0, 8'd0);
    tick();
    expect_out("busy_write_dropped", 8'h02, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_done("busy_drain");
    expect_out("busy_full_len", 8'h07, 1'b0, 1'b0, 1'b1, 8'd0);
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 8'h5A;
    start_run(6'd1);
    wr_en = 1'b0;
    expect_out("write_start_bypass", 8'h5A, 1'b1, 1'b1, 1'b0, 8'd0);
    tick();
    expect_out("len1_done", 8'h5A, 1'b0, 1'b0, 1'b1, 8'd0);
    found_pattern = 1'b1;
    tick(2);
    found_pattern = 1'b0;
    expect_out("done_flag_ignored", 8'h5A, 1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  initial begin
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    stream_len    = '0;
    start         = 1'b0;
    found_pattern = 1'b0;
    test_reset();
    test_stream();
    test_match();
    test_held_flag();
    test_last_byte();
    test_reset_mid();
    test_len0_and_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
